// File: rtl/fifo_serial_tx_if.sv
// rtl/fifo_serial_tx_if.sv - FIFO read port, enable and serial line bundle for fifo_serial_tx
interface fifo_serial_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_deq;
    logic                  tx_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    // master: the transmitter; slave: the FIFO and line environment around it
    modport master (
        input  fifo_empty, fifo_data, tx_en,
        output fifo_deq, tx, busy, frame_done
    );

    modport slave (
        output fifo_empty, fifo_data, tx_en,
        input  fifo_deq, tx, busy, frame_done
    );
endinterface

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - drains a show-ahead FIFO into start/data/parity/stop serial frames
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    fifo_serial_tx_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [NW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  deq_q, deq_d;
    logic                  done_q, done_d;
    logic                  bit_end;
    logic                  capture;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        capture = 1'b0;
        bit_end = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.tx_en && !bus.fifo_empty) capture = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bus.tx_en && !bus.fifo_empty) capture = 1'b1;
                    else                              state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The head word is latched here; the FIFO pops on the following cycle.
        if (capture) begin
            state_d = S_START;
            baud_d  = '0;
            shift_d = bus.fifo_data;
            par_d   = ^bus.fifo_data;
        end

        // Outputs are derived from next state so the registered copies line up with it.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        deq_d  = capture;
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            deq_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            deq_q   <= deq_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_deq   = deq_q;
    assign bus.frame_done = done_q;

endmodule
